// File: rtl/neuron_layer_mac_if.sv
// Handshake and data bundle for neuron_layer_mac.
// master: drives start, x0..x3, w_flat, b_flat; slave: drives y0..y3, busy, done.
interface neuron_layer_mac_if;
    logic              start;
    logic signed [7:0] x0;
    logic signed [7:0] x1;
    logic signed [7:0] x2;
    logic signed [7:0] x3;
    logic [127:0]      w_flat;
    logic [31:0]       b_flat;
    logic signed [7:0] y0;
    logic signed [7:0] y1;
    logic signed [7:0] y2;
    logic signed [7:0] y3;
    logic              busy;
    logic              done;

    modport master (
        output start, x0, x1, x2, x3, w_flat, b_flat,
        input  y0, y1, y2, y3, busy, done
    );

    modport slave (
        input  start, x0, x1, x2, x3, w_flat, b_flat,
        output y0, y1, y2, y3, busy, done
    );
endinterface

// File: rtl/neuron_layer_mac.sv
// 4-input / 4-neuron fully-connected layer on one time-shared 8x8 multiplier.
// Ports: clk, reset (async, active-high), bus (neuron_layer_mac_if.slave).
// Build option: define NN_RELU_EN to apply ReLU after saturation.
module neuron_layer_mac #(
    parameter int SHIFT = 6
) (
    input logic               clk,
    input logic               reset,
    neuron_layer_mac_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         cnt;
    logic [1:0]         n;
    logic [1:0]         i;
    logic signed [7:0]  xl [4];
    logic signed [7:0]  y  [4];
    logic signed [17:0] acc;

    logic signed [7:0]  w_sel;
    logic signed [7:0]  x_sel;
    logic signed [7:0]  b_sel;
    logic signed [15:0] prod;
    logic signed [17:0] base;
    logic signed [17:0] sum;
    logic signed [17:0] shifted;
    logic signed [7:0]  sat;
    logic signed [7:0]  act;
    logic               busy;
    logic               done;

    // cnt walks n-major/i-minor, so it is also the weight index 4n+i
    assign n = cnt[3:2];
    assign i = cnt[1:0];

    assign w_sel = bus.w_flat[{cnt, 3'b000} +: 8];
    assign b_sel = bus.b_flat[{n, 3'b000} +: 8];
    assign x_sel = xl[i];
    assign prod  = w_sel * x_sel;

    // first product of a neuron starts from the bias instead of acc
    assign base = (i == 2'd0) ? {{10{b_sel[7]}}, b_sel} : acc;
    assign sum  = base + {{2{prod[15]}}, prod};

    assign shifted = sum >>> SHIFT;

    always_comb begin
        sat = shifted[7:0];
        if (shifted > 18'sd127) begin
            sat = 8'sd127;
        end else if (shifted < -18'sd128) begin
            sat = -8'sd128;
        end
    end

`ifdef NN_RELU_EN
    assign act = sat[7] ? 8'sd0 : sat;
`else
    assign act = sat;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == 4'd15) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            acc <= '0;
            for (int k = 0; k < 4; k++) begin
                xl[k] <= '0;
                y[k]  <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        xl[0] <= bus.x0;
                        xl[1] <= bus.x1;
                        xl[2] <= bus.x2;
                        xl[3] <= bus.x3;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc <= sum;
                    cnt <= cnt + 4'd1;
                    if (i == 2'd3) begin
                        y[n] <= act;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.y0   = y[0];
    assign bus.y1   = y[1];
    assign bus.y2   = y[2];
    assign bus.y3   = y[3];
    assign bus.busy = busy;
    assign bus.done = done;

endmodule

// File: tb/tb_neuron_layer_mac.sv
// Directed bench for neuron_layer_mac with an expected-result queue.
// Checks reset, latency, handshake, arithmetic corners and control corners.
module tb_neuron_layer_mac;

    localparam int SH = 6;

    logic clk;
    logic reset;

    neuron_layer_mac_if bus ();

    neuron_layer_mac #(.SHIFT(SH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk;
    int n_pass;
    int n_fail;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] xv,
                                          input logic [127:0] w,
                                          input logic [31:0] b);
        logic [31:0] r;
        int s;
        int wi;
        int xi;
        r = '0;
        for (int nn = 0; nn < 4; nn++) begin
            s = int'($signed(b[8*nn +: 8]));
            for (int ii = 0; ii < 4; ii++) begin
                wi = int'($signed(w[8*(4*nn+ii) +: 8]));
                xi = int'($signed(xv[8*ii +: 8]));
                s  = s + wi * xi;
            end
            s = s >>> SH;
            if (s > 127) s = 127;
            else if (s < -128) s = -128;
`ifdef NN_RELU_EN
            if (s < 0) s = 0;
`endif
            r[8*nn +: 8] = s[7:0];
        end
        return r;
    endfunction

    function automatic logic [31:0] yv();
        return {bus.y3, bus.y2, bus.y1, bus.y0};
    endfunction

    task automatic drive(input logic [31:0] xv, input logic [127:0] w,
                         input logic [31:0] b);
        bus.x0     = xv[7:0];
        bus.x1     = xv[15:8];
        bus.x2     = xv[23:16];
        bus.x3     = xv[31:24];
        bus.w_flat = w;
        bus.b_flat = b;
    endtask

    task automatic do_layer(input string tag, input logic [31:0] xv,
                            input logic [127:0] w, input logic [31:0] b,
                            input bit inject);
        int lat;
        int bcnt;
        int dcnt;
        @(posedge clk); #1;
        drive(xv, w, b);
        bus.start = 1'b1;
        exp_q.push_back(model(xv, w, b));
        @(posedge clk); #1;
        bus.start = 1'b0;
        // scramble x after acceptance: latched copy must be used
        bus.x0 = 8'($urandom);
        bus.x1 = 8'($urandom);
        bus.x2 = 8'($urandom);
        bus.x3 = 8'($urandom);
        lat  = 0;
        bcnt = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) bcnt++;
            bus.start = inject && (lat == 3 || lat == 10);
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        check({tag, " latency"}, lat, 16);
        check({tag, " busy cycles"}, bcnt, 16);
        check({tag, " busy at done"}, bus.busy, 1'b0);
        if (exp_q.size() > 0) check({tag, " y"}, yv(), exp_q.pop_front());
        else check({tag, " y (empty queue)"}, 1, 0);
        @(posedge clk); #1;
        check({tag, " done width"}, bus.done, 1'b0);
        if (inject) begin
            dcnt = 0;
            repeat (20) begin
                @(posedge clk); #1;
                if (bus.done) dcnt++;
            end
            check({tag, " extra done"}, dcnt, 0);
        end
    endtask

    initial begin
        logic [127:0] w;
        logic [31:0]  b;
        logic [31:0]  xv;
        int dcnt;
        n_chk  = 0;
        n_pass = 0;
        n_fail = 0;

        reset     = 1'b1;
        bus.start = 1'b0;
        drive($urandom, {$urandom, $urandom, $urandom, $urandom}, $urandom);
        #3;
        check("reset y", yv(), 32'h0);
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        dcnt  = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.done) dcnt++;
        end
        check("idle no done", dcnt, 0);

        // basic: w_n0 = 64, x0 = 64 -> 4096 >>> 6 = 64
        w = '0;
        for (int k = 0; k < 4; k++) w[8*(4*k) +: 8] = 8'd64;
        do_layer("basic", 32'h0000_0040, w, 32'h0, 1'b0);
        check("basic y0", 32'(bus.y0), 32'h40);

        // saturation
        w = {16{8'd127}};
        do_layer("sat", {4{8'd127}}, w, {4{8'd127}}, 1'b0);

        // negative product: 64 * -64
        w = '0;
        w[7:0] = 8'hC0;
        do_layer("neg", 32'h0000_0040, w, 32'h0, 1'b0);

        // bias rounding: 100 >>> 6 = 1, -100 >>> 6 = -2
        do_layer("bias", 32'h0, '0, {8'd0, 8'h9C, 8'd100, 8'd0}, 1'b0);

        // random operands with ignored extra starts
        xv = $urandom;
        w  = {$urandom, $urandom, $urandom, $urandom};
        b  = $urandom;
        do_layer("inject", xv, w, b, 1'b1);

        // back-to-back random
        do_layer("rand", $urandom, {$urandom, $urandom, $urandom, $urandom},
                 $urandom, 1'b0);

        // reset at RUN cycle 8 after neuron 0 has been written
        w = '0;
        for (int k = 0; k < 4; k++) w[8*(4*k) +: 8] = 8'd64;
        @(posedge clk); #1;
        drive(32'h0000_0040, w, 32'h0);
        bus.start = 1'b1;
        exp_q.push_back(model(32'h0000_0040, w, 32'h0));
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        check("mid y0 written", 32'(bus.y0), 32'h40);
        reset = 1'b1;
        #1;
        check("mid reset busy", bus.busy, 1'b0);
        check("mid reset y", yv(), 32'h0);
        check("mid reset done", bus.done, 1'b0);
        void'(exp_q.pop_back());
        #8;
        reset = 1'b0;
        do_layer("after reset", $urandom,
                 {$urandom, $urandom, $urandom, $urandom}, $urandom, 1'b0);

        check("queue drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
